hs_sink_fifo: RTL and testbench
===============================

HS_SINK_FIFO -- requirements
Module: hs_sink_fifo

Interface
REQ-001 Parameter WIDTH, default 3: data width of the bundled-data channel and of the FIFO entries.
REQ-002 Parameter DEPTH, default 4: FIFO entries; power of two, minimum 2.
REQ-003 Parameter SYNC_STAGES, default 2: flops in the req_in synchronizer; minimum 2.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 req_in  in  1  two-phase (transition) request from the upstream stage; asynchronous to clk.
REQ-007 data_in  in  WIDTH  bundled data; stable from before each req_in transition until the matching ack_out transition.
REQ-008 ack_out  out  1  two-phase acknowledge to upstream; one toggle per accepted token.
REQ-009 out_valid  out  1  FIFO non-empty.
REQ-010 out_data  out  WIDTH  head-of-FIFO entry; valid when out_valid=1.
REQ-011 out_ready  in  1  consumer accepts the head entry when out_valid and out_ready are both 1 (pop).
REQ-012 count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 pending  out  1  a synchronized request is waiting for acknowledgement (req_s != ack_out).

Function
REQ-014 req_in SHALL pass through SYNC_STAGES flops; the last stage is req_s; data_in SHALL NOT be synchronized.
REQ-015 pending = (req_s != ack_out), combinational from registers.
REQ-016 push = pending && (count < DEPTH || pop); pop = out_valid && out_ready.
REQ-017 On push, the edge SHALL write data_in to mem[wr_ptr], advance wr_ptr modulo DEPTH, and toggle ack_out.
REQ-018 Latency: a req_in transition set up before edge k SHALL reach req_s at edge k+SYNC_STAGES-1; with space available, ack_out SHALL toggle at edge k+SYNC_STAGES.
REQ-019 At most one push per cycle; ack_out SHALL toggle at most once per token and never while pending=0.
REQ-020 If the FIFO is full and no pop occurs, the push SHALL be withheld: ack_out holds and pending stays 1 (back-pressure); the push SHALL occur on the first cycle with space or a pop.
REQ-021 On pop, rd_ptr SHALL advance modulo DEPTH; out_data = mem[rd_ptr] (first-word fall-through, no extra latency).
REQ-022 Simultaneous push and pop: count unchanged; allowed when full (pop frees the slot) and when count=1 (the new entry appears next cycle).
REQ-023 count SHALL increment on push only, decrement on pop only, and never exceed DEPTH or underflow.
REQ-024 Pointer wrap-around SHALL preserve FIFO order across any number of wraps.
REQ-025 pop with out_valid=0 SHALL be ignored; out_ready is don't-care when empty.

Reset
REQ-026 With rst=1 at an edge: sync flops=0, ack_out=0, wr_ptr=rd_ptr=0, count=0; thus out_valid=0 and pending=0 after that edge.
REQ-027 mem contents SHALL NOT be reset; out_data is don't-care while out_valid=0.
REQ-028 Reset mid-operation SHALL discard all stored and in-flight tokens; if req_in is 1 after reset release, it SHALL be treated as a new pending token (upstream is reset concurrently).

Structure
REQ-029 The shared package pipe_pkg SHALL hold the default WIDTH, DEPTH and SYNC_STAGES constants and a data typedef, shared with the other pipeline stages.
REQ-030 The synchronizer SHALL be a separate sub-module sync_ff (parameter STAGES, ports clk, rst, d, q); the FIFO and handshake logic stay in hs_sink_fifo.

Verification
REQ-031 Reset, then toggle req_in 0->1 with data_in=1 -> ack_out toggles 0->1 exactly 2 edges later; out_valid=1, out_data=1, count=1.
REQ-032 Four tokens 1,2,3,4, each req toggle issued after the previous ack toggle, out_ready=0 -> count=4, each ack toggles once; a fifth token (5) leaves pending=1 and ack_out unchanged; asserting out_ready for one cycle pops 1, and in that same cycle 5 is pushed and ack_out toggles.
REQ-033 Full FIFO with out_ready=1 held and tokens streaming -> output order 1,2,3,4,5,... with no loss; count never exceeds 4.
REQ-034 count=1 with simultaneous push and pop -> count stays 1; next out_data equals the newly pushed value.
REQ-035 Assert rst with count=3 and pending=1 -> next edge count=0, out_valid=0, ack_out=0; req_in=1 held after release -> one push of the current data_in, ack_out goes 0->1.
REQ-036 Write 10 tokens with alternating out_ready -> read data matches write order across pointer wrap; ack toggle count equals 10.

Source files
------------

// File: rtl/pipe_pkg.sv
// Constants and types shared by the bundled-data pipeline stages.
package pipe_pkg;

    localparam int unsigned DefWidth      = 3;
    localparam int unsigned DefDepth      = 4;
    localparam int unsigned DefSyncStages = 2;

    typedef logic [DefWidth-1:0] data_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level; q is the last stage.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/hs_sink_fifo.sv
// Two-phase bundled-data sink: synchronizes req_in, captures data_in into a
// first-word fall-through FIFO and returns a transition ack per stored token.
module hs_sink_fifo
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH       = DefWidth,
    parameter int unsigned DEPTH       = DefDepth,
    parameter int unsigned SYNC_STAGES = DefSyncStages
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_in,
    input  logic [WIDTH-1:0]         data_in,
    output logic                     ack_out,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     pending
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic             req_s;
    logic             ack_q, ack_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push, pop;

    // data_in is bundled with req_in and deliberately not synchronized.
    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (req_in),
        .q   (req_s)
    );

    always_comb begin
        out_valid = (count_q != '0);
        pending   = (req_s != ack_q);
        pop       = out_valid && out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        push      = pending && ((count_q < CW'(DEPTH)) || pop);

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ack_d     = ack_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            ack_d    = ~ack_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            ack_q    <= ack_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left unreset; only occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign ack_out  = ack_q;
    assign out_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: tb/tb_hs_sink_fifo.sv
// Directed bench for hs_sink_fifo: queue-level model checked every cycle,
// plus literal expectations for the handshake latency and back-pressure cases.
module tb_hs_sink_fifo;

    localparam int unsigned W = 3;
    localparam int unsigned D = 4;
    localparam int unsigned S = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_in;
    logic [W-1:0] data_in;
    logic         ack_out;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic [2:0]   count;
    logic         pending;

    int errors = 0;
    int checks = 0;

    hs_sink_fifo #(
        .WIDTH       (W),
        .DEPTH       (D),
        .SYNC_STAGES (S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .data_in   (data_in),
        .ack_out   (ack_out),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    // Model: req_in seen through S edges of delay, FIFO as a queue.
    bit           hist [S];
    bit           ack_m;
    logic [W-1:0] q_m [$];
    bit           model_on = 0;

    always @(posedge clk) begin
        bit pend, popm, pushm;
        if (rst) begin
            for (int i = 0; i < S; i++) hist[i] = 0;
            ack_m = 0;
            q_m.delete();
        end else begin
            pend  = (hist[S-1] != ack_m);
            popm  = (q_m.size() != 0) && (out_ready === 1'b1);
            pushm = pend && ((q_m.size() < D) || popm);
            if (popm) void'(q_m.pop_front());
            if (pushm) begin
                q_m.push_back(data_in);
                ack_m = ~ack_m;
            end
            for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = req_in;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare, plus ack-toggle counting and pop recording.
    int           ack_toggles = 0;
    logic         ack_prev = 1'b0;
    bit           record = 0;
    logic [W-1:0] popped [$];

    always @(negedge clk) begin
        if (model_on) begin
            chk("ack_out", int'(ack_out), int'(ack_m));
            chk("out_valid", int'(out_valid), int'(q_m.size() != 0));
            chk("count", int'(count), q_m.size());
            chk("pending", int'(pending), int'(hist[S-1] != ack_m));
            if (q_m.size() != 0) chk("out_data", int'(out_data), int'(q_m[0]));
            if (ack_out !== ack_prev) ack_toggles++;
            ack_prev = ack_out;
            if (record && out_valid && out_ready) popped.push_back(out_data);
        end
    end

    bit alt_mode = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (alt_mode) out_ready = ~out_ready;
        end
    endtask

    task automatic send(input logic [W-1:0] v);
        logic prev;
        int   n;
        prev    = ack_out;
        data_in = v;
        req_in  = ~req_in;
        n = 0;
        while (ack_out === prev && n < 20) begin
            tick(1);
            n++;
        end
        checks++;
        if (ack_out === prev) begin
            errors++;
            $display("FAIL send_ack_timeout: ack_out %0b still equals %0b for token %0d",
                     ack_out, prev, v);
        end
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (out_valid === 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        out_ready = 1'b0;
        chk("drain_empty", int'(out_valid), 0);
    endtask

    initial begin
        int base;
        rst = 1'b1; req_in = 1'b0; data_in = '0; out_ready = 1'b0;
        tick(3);
        rst = 1'b0;
        model_on = 1;
        ack_prev = 1'b0;
        chk("rst_count", int'(count), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_ack", int'(ack_out), 0);
        chk("rst_pending", int'(pending), 0);

        // First token: ack exactly two edges after the request edge.
        data_in = 3'd1; req_in = 1'b1;
        tick(1); chk("lat_edge_k", int'(ack_out), 0);
        tick(1); chk("lat_edge_k1", int'(ack_out), 0);
                 chk("lat_pending", int'(pending), 1);
        tick(1); chk("lat_edge_k2", int'(ack_out), 1);
                 chk("lat_valid", int'(out_valid), 1);
                 chk("lat_data", int'(out_data), 1);
                 chk("lat_count", int'(count), 1);

        // Fill, then back-pressure a fifth token.
        send(3'd2); send(3'd3); send(3'd4);
        chk("full_count", int'(count), 4);
        data_in = 3'd5; req_in = ~req_in;
        tick(4);
        chk("bp_pending", int'(pending), 1);
        chk("bp_ack", int'(ack_out), 0);
        chk("bp_count", int'(count), 4);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("bp_release_ack", int'(ack_out), 1);
        chk("bp_release_count", int'(count), 4);
        chk("bp_release_head", int'(out_data), 2);

        // Streaming through a full FIFO with the consumer always ready.
        out_ready = 1'b1;
        send(3'd6); send(3'd7); send(3'd0); send(3'd1); send(3'd2);
        drain();

        // Push and pop in the same cycle at count=1.
        send(3'd6);
        chk("c1_count", int'(count), 1);
        data_in = 3'd7; req_in = ~req_in;
        tick(2);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("c1_pp_count", int'(count), 1);
        chk("c1_pp_data", int'(out_data), 7);

        // Reset with stored and in-flight tokens; req_in=1 held across release.
        send(3'd1); send(3'd2);
        chk("pre_rst_count", int'(count), 3);
        data_in = 3'd5; req_in = 1'b1;
        tick(2);
        chk("pre_rst_pending", int'(pending), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_ack", int'(ack_out), 0);
        tick(2);
        chk("post_rst_ack_hold", int'(ack_out), 0);
        tick(1);
        chk("post_rst_ack", int'(ack_out), 1);
        chk("post_rst_count", int'(count), 1);
        chk("post_rst_data", int'(out_data), 5);
        drain();

        // Ten tokens with alternating out_ready, across several pointer wraps.
        base = ack_toggles;
        record = 1;
        alt_mode = 1;
        for (int i = 1; i <= 10; i++) send(W'(i));
        alt_mode = 0;
        drain();
        record = 0;
        chk("wrap_ack_toggles", ack_toggles - base, 10);
        chk("wrap_pop_count", popped.size(), 10);
        for (int i = 0; i < 10 && i < popped.size(); i++)
            chk($sformatf("wrap_order[%0d]", i), int'(popped[i]), (i + 1) % 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
